rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
Parametrised multi-port register file, the successor to the single-port rf block.
- Generalised in data width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass and write-collision detection with fixed priority.
- Sits between the datapath and issue logic; bench access goes through a parametrised interface and wrap, same as the current rf.

Parameters:
DATA_W  32  width of each register in bits
ADDR_W  5  address width; depth = 2**ADDR_W registers
NR  2  number of read ports (1..8)
NW  2  number of write ports (1..4)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  NW  per-port write enable
wr_addr  in  NW*ADDR_W  write addresses, port p at [p*ADDR_W +: ADDR_W]
wr_data  in  NW*DATA_W  write data, port p at [p*DATA_W +: DATA_W]
rd_en  in  NR  per-port read enable
rd_addr  in  NR*ADDR_W  read addresses, port q at [q*ADDR_W +: ADDR_W]
rd_data  out  NR*DATA_W  registered read data, port q at [q*DATA_W +: DATA_W]
rd_valid  out  NR  high one cycle after an accepted read on port q
wr_conflict  out  1  pulses one cycle after two or more enabled write ports target the same address
conflict_cnt  out  16  saturating count of cycles with a write collision

Behaviour:
- Reset is synchronous, active-high, and has priority over everything.
  - Every register is cleared to 0.
  - rd_data, rd_valid, wr_conflict and conflict_cnt are all 0.
  - Writes and reads presented in the reset cycle are discarded.
- Write: on a rising edge with wr_en[p]=1, mem[wr_addr[p]] <= wr_data[p].
- Write collision: two or more enabled ports with the same address.
  - The highest port index wins; lower ports to that address are dropped.
  - wr_conflict = 1 in the following cycle, otherwise 0.
  - conflict_cnt increments by 1 per collision cycle, regardless of how many ports collided, and saturates at 16'hFFFF.
- Read: rd_en[q]=1 at edge k gives rd_data[q] at edge k+1, and rd_valid[q]=1 for that cycle.
  - Latency is 1 cycle.
  - With rd_en[q]=0, rd_data[q] holds its previous value and rd_valid[q]=0.
- Bypass (write-first): if an enabled write and a read target the same address in the same cycle, rd_data returns the new write data. When several writes hit that address, the winning (highest-index) port's data is returned.
- Multiple read ports may read the same address in the same cycle; each receives identical data.
- Addresses are always in range (2**ADDR_W depth), so there is no out-of-range condition.
- Reset asserted mid-stream:
  - Any read issued in the reset cycle returns rd_valid=0 next cycle.
  - The first read after reset deasserts returns 0 unless the register was written in between.
- No stalls or backpressure; every port is accepted every cycle.

Optional Feature:
Macro RF_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Writes to address 0 are ignored and do not count as collisions.
  - Reads of address 0 always return 0, including through the bypass path.
- Undefined: address 0 is an ordinary register with identical behaviour to all others.

Test Plan:
1. Reset, then read all 32 addresses on port 0 -> every rd_data = 0, rd_valid high exactly one cycle after each rd_en, wr_conflict = 0, conflict_cnt = 0.
2. Write 0xDEADBEEF to addr 7 on port 0 and 0x12345678 to addr 9 on port 1 in one cycle; next cycle read 7 on port 0 and 9 on port 1 -> 0xDEADBEEF and 0x12345678 one cycle later.
3. Same cycle: write 0xA5A5A5A5 to addr 3 on port 0 and read addr 3 on port 1 -> rd_data[1] = 0xA5A5A5A5 next cycle (bypass).
4. Same cycle: port 0 writes 0x11111111 to addr 4 and port 1 writes 0x22222222 to addr 4 -> mem[4] = 0x22222222, wr_conflict = 1 for exactly one cycle, conflict_cnt = 1. Repeat 3 times -> conflict_cnt = 4.
5. Write 0xCAFEF00D to addr 5, then assert rst one cycle while port 0 reads addr 5 -> rd_valid = 0 after the reset cycle; read after reset returns 0.
6. With RF_ZERO_REG_EN: write 0xFFFFFFFF to addr 0, then read addr 0 -> 0. Without the macro the same sequence returns 0xFFFFFFFF.

Source files
------------

// File: rtl/rf_multiport.sv
// rf_multiport: parametrised multi-port register file with write-first bypass and collision counting.
// Optional RF_ZERO_REG_EN hardwires register 0 to zero.
module rf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NR     = 2,
    parameter int NW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NW-1:0]        wr_en,
    input  logic [NW*ADDR_W-1:0] wr_addr,
    input  logic [NW*DATA_W-1:0] wr_data,
    input  logic [NR-1:0]        rd_en,
    input  logic [NR*ADDR_W-1:0] rd_addr,
    output logic [NR*DATA_W-1:0] rd_data,
    output logic [NR-1:0]        rd_valid,
    output logic                 wr_conflict,
    output logic [15:0]          conflict_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [NW-1:0]        we;
    logic                 collide;
    logic [NR*DATA_W-1:0] rd_next;

    // Effective write enables; with the zero register, writes to address 0 vanish entirely.
    always_comb begin
        we = '0;
        for (int p = 0; p < NW; p++) begin
`ifdef RF_ZERO_REG_EN
            we[p] = wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != '0);
`else
            we[p] = wr_en[p];
`endif
        end
    end

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NW; i++)
            for (int j = i + 1; j < NW; j++)
                if (we[i] && we[j] && wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])
                    collide = 1'b1;
    end

    // Later ports override earlier ones, so the highest-index writer wins the bypass.
    always_comb begin
        rd_next = '0;
        for (int q = 0; q < NR; q++) begin
            rd_next[q*DATA_W +: DATA_W] = mem[rd_addr[q*ADDR_W +: ADDR_W]];
            for (int p = 0; p < NW; p++)
                if (we[p] && wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[q*ADDR_W +: ADDR_W])
                    rd_next[q*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++)
                mem[a] <= '0;
            rd_data      <= '0;
            rd_valid     <= '0;
            wr_conflict  <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            for (int p = 0; p < NW; p++)
                if (we[p])
                    mem[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
            for (int q = 0; q < NR; q++)
                if (rd_en[q])
                    rd_data[q*DATA_W +: DATA_W] <= rd_next[q*DATA_W +: DATA_W];
            rd_valid    <= rd_en;
            wr_conflict <= collide;
            if (collide && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed-vector bench for rf_multiport (2 read / 2 write ports, 32x32).
// Expectations for address 0 follow RF_ZERO_REG_EN.
module tb_rf_multiport;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wr_en = '0;
    logic [9:0]  wr_addr = '0;
    logic [63:0] wr_data = '0;
    logic [1:0]  rd_en = '0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic        wr_conflict;
    logic [15:0] conflict_cnt;

    int vectors = 0;
    int miscompares = 0;

`ifdef RF_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    rf_multiport #(.DATA_W(32), .ADDR_W(5), .NR(2), .NW(2)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_conflict(wr_conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0;
        wr_en = '0;
        rd_en = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (rd_valid !== 2'b00 || rd_data !== 64'h0 || wr_conflict !== 1'b0 || conflict_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b data=%h conf=%b cnt=%h expected all zero", rd_valid, rd_data, wr_conflict, conflict_cnt);
        end
        for (int a = 0; a < 32; a++) begin
            rd_en = 2'b01;
            rd_addr = {5'd0, 5'(a)};
            tick();
            vectors++;
            if (rd_data[31:0] !== 32'h0 || rd_valid !== 2'b01 || wr_conflict !== 1'b0 || conflict_cnt !== 16'h0) begin
                miscompares++;
                $display("FAIL reset_read addr %0d: data=%h valid=%b conf=%b cnt=%h expected 0/01/0/0", a, rd_data[31:0], rd_valid, wr_conflict, conflict_cnt);
            end
        end
        idle();
        tick();
        vectors++;
        if (rd_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_valid_drop: valid=%b expected 00", rd_valid);
        end
    endtask

    task automatic test_write_read();
        wr_en = 2'b11;
        wr_addr = {5'd9, 5'd7};
        wr_data = {32'h12345678, 32'hDEADBEEF};
        tick();
        idle();
        rd_en = 2'b11;
        rd_addr = {5'd9, 5'd7};
        tick();
        vectors++;
        if (rd_data !== {32'h12345678, 32'hDEADBEEF} || rd_valid !== 2'b11) begin
            miscompares++;
            $display("FAIL write_read: data=%h valid=%b expected 12345678deadbeef/11", rd_data, rd_valid);
        end
        idle();
    endtask

    task automatic test_bypass();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd3};
        wr_data = {32'h0, 32'hA5A5A5A5};
        rd_en = 2'b10;
        rd_addr = {5'd3, 5'd0};
        tick();
        vectors++;
        if (rd_data !== {32'hA5A5A5A5, 32'hDEADBEEF} || rd_valid !== 2'b10) begin
            miscompares++;
            $display("FAIL bypass_hold: data=%h valid=%b expected a5a5a5a5deadbeef/10", rd_data, rd_valid);
        end
        idle();
    endtask

    task automatic test_collision();
        for (int i = 0; i < 4; i++) begin
            wr_en = 2'b11;
            wr_addr = {5'd4, 5'd4};
            wr_data = {32'h22222222, 32'h11111111};
            rd_en = (i == 0) ? 2'b01 : 2'b00;
            rd_addr = {5'd0, 5'd4};
            tick();
            idle();
            vectors++;
            if (wr_conflict !== 1'b1 || conflict_cnt !== 16'(i + 1)) begin
                miscompares++;
                $display("FAIL collision_%0d: conf=%b cnt=%0d expected 1/%0d", i, wr_conflict, conflict_cnt, i + 1);
            end
            if (i == 0) begin
                vectors++;
                if (rd_data[31:0] !== 32'h22222222) begin
                    miscompares++;
                    $display("FAIL collision_bypass: data=%h expected 22222222", rd_data[31:0]);
                end
            end
            tick();
            vectors++;
            if (wr_conflict !== 1'b0 || conflict_cnt !== 16'(i + 1)) begin
                miscompares++;
                $display("FAIL collision_pulse_%0d: conf=%b cnt=%0d expected 0/%0d", i, wr_conflict, conflict_cnt, i + 1);
            end
        end
        rd_en = 2'b11;
        rd_addr = {5'd4, 5'd4};
        tick();
        vectors++;
        if (rd_data !== {32'h22222222, 32'h22222222}) begin
            miscompares++;
            $display("FAIL collision_winner: data=%h expected 2222222222222222", rd_data);
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd5};
        wr_data = {32'h0, 32'hCAFEF00D};
        tick();
        idle();
        rst = 1'b1;
        rd_en = 2'b01;
        rd_addr = {5'd0, 5'd5};
        tick();
        idle();
        vectors++;
        if (rd_valid !== 2'b00 || rd_data !== 64'h0 || conflict_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL midreset: valid=%b data=%h cnt=%h expected 00/0/0", rd_valid, rd_data, conflict_cnt);
        end
        rd_en = 2'b01;
        tick();
        vectors++;
        if (rd_data[31:0] !== 32'h0 || rd_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL midreset_read: data=%h valid=%b expected 0/01", rd_data[31:0], rd_valid);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        logic [31:0] exp_ff;
        exp_ff = ZERO ? 32'h0 : 32'hFFFFFFFF;
        wr_en = 2'b01;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hFFFFFFFF};
        tick();
        idle();
        rd_en = 2'b01;
        rd_addr = {5'd0, 5'd0};
        tick();
        vectors++;
        if (rd_data[31:0] !== exp_ff) begin
            miscompares++;
            $display("FAIL zero_reg_read: data=%h expected %h", rd_data[31:0], exp_ff);
        end
        wr_en = 2'b11;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'hFFFFFFFF, 32'h00001111};
        rd_en = 2'b10;
        rd_addr = {5'd0, 5'd0};
        tick();
        idle();
        vectors++;
        if (rd_data[63:32] !== exp_ff || wr_conflict !== !ZERO) begin
            miscompares++;
            $display("FAIL zero_reg_bypass: data=%h conf=%b expected %h/%b", rd_data[63:32], wr_conflict, exp_ff, !ZERO);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_collision();
        test_reset_midstream();
        test_zero_reg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
